// File: rtl/rca_seq_pkg.sv
// Shared definitions for the sequential ripple-carry adder controller.
// Used by rca_slice4 and rca_seq_ctrl; optional macro SUBTRACT_EN is handled in those files.
package rca_seq_pkg;

   localparam int unsigned SLICE_W = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      StIdle = ST_IDLE,
      StRun  = ST_RUN,
      StDone = ST_DONE
   } state_e;

endpackage

// File: rtl/rca_seq_ctrl_if.sv
// Request/result handshake bundle for rca_seq_ctrl.
// The sub signal exists only when SUBTRACT_EN is defined.
interface rca_seq_ctrl_if #(
   parameter int unsigned WIDTH = 16
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
`ifdef SUBTRACT_EN
   logic             sub;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             busy;

   // Requester/consumer side.
   modport master (
`ifdef SUBTRACT_EN
      output sub,
`endif
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, busy
   );

   // Controller side.
   modport slave (
`ifdef SUBTRACT_EN
      input  sub,
`endif
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, sum, cout, ovf, busy
   );

endinterface

// File: rtl/rca_slice4.sv
// Combinational 4-bit ripple-carry slice built from a chain of full adders.
module rca_slice4
   import rca_seq_pkg::*;
(
   input  logic [SLICE_W-1:0] a4,
   input  logic [SLICE_W-1:0] b4,
   input  logic               cin,
   output logic [SLICE_W-1:0] s4,
   output logic               co
);

   logic [SLICE_W:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
      assign s4[i]  = a4[i] ^ b4[i] ^ c[i];
      assign c[i+1] = (a4[i] & b4[i]) | (c[i] & (a4[i] ^ b4[i]));
   end

   assign co = c[SLICE_W];

endmodule

// File: rtl/rca_seq_ctrl.sv
// Sequences one 4-bit ripple-carry slice over WIDTH-bit operands, one nibble per clock, LSB first.
// Define SUBTRACT_EN to add the sub request (a - b via inverted b and carry-in of 1).
module rca_seq_ctrl
   import rca_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input logic           clk,
   input logic           reset,
   rca_seq_ctrl_if.slave bus
);

   localparam int unsigned NSLICE = WIDTH / SLICE_W;
   localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [SLICE_W-1:0] sl_a, sl_b, sl_s;
   logic               sl_co;

   assign sl_a = a_q[SLICE_W*idx_q +: SLICE_W];
   assign sl_b = b_q[SLICE_W*idx_q +: SLICE_W];

   rca_slice4 u_slice (
      .a4  (sl_a),
      .b4  (sl_b),
      .cin (carry_q),
      .s4  (sl_s),
      .co  (sl_co)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      unique case (state_q)
         StIdle: begin
            // in_ready is high throughout IDLE, so in_valid alone is the accept.
            if (bus.in_valid) begin
               a_d     = bus.a;
`ifdef SUBTRACT_EN
               b_d     = bus.sub ? ~bus.b : bus.b;
               carry_d = bus.sub;
`else
               b_d     = bus.b;
               carry_d = 1'b0;
`endif
               idx_d   = '0;
               sum_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            sum_d[SLICE_W*idx_q +: SLICE_W] = sl_s;
            carry_d = sl_co;
            if (idx_q == IDX_LAST) begin
               idx_d   = '0;
               cout_d  = sl_co;
               // b_q already holds the effective (possibly inverted) operand.
               ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (sl_s[SLICE_W-1] != a_q[WIDTH-1]);
               state_d = StDone;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         StDone: begin
            if (bus.out_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.in_ready  = (state_q == StIdle);
   assign bus.out_valid = (state_q == StDone);
   assign bus.busy      = (state_q != StIdle);
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Self-checking bench for rca_seq_ctrl: vector table plus scoreboard, with backpressure and
// mid-operation reset sequences. SUBTRACT_EN adds subtract vectors.
module tb_rca_seq_ctrl;

   localparam int unsigned WIDTH = 16;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   rca_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

   rca_seq_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        sub;
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   typedef struct {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } res_t;

   int   n_checks = 0;
   int   n_fail   = 0;
   res_t sb[$];
   vec_t vecs[$];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic s);
      logic [15:0] be;
      logic [16:0] t;
      res_t        r;
      be     = s ? ~b : b;
      t      = {1'b0, a} + {1'b0, be} + {16'b0, s};
      r.sum  = t[15:0];
      r.cout = t[16];
      r.ovf  = (a[15] == be[15]) && (t[15] != a[15]);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accepts one operation, checks latency and result, optionally holds out_ready low.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input res_t exp, input int hold);
      int   cyc;
      res_t e;
      check("in_ready_idle", 16'(bus.in_ready), 16'd1);
      bus.a         = a;
      bus.b         = b;
`ifdef SUBTRACT_EN
      bus.sub       = s;
`endif
      bus.in_valid  = 1'b1;
      bus.out_ready = (hold == 0);
      tick();
      sb.push_back(exp);
      bus.in_valid = 1'b0;
      bus.a        = 16'($urandom);
      bus.b        = 16'($urandom);
`ifdef SUBTRACT_EN
      bus.sub      = ~s;
`endif
      check("in_ready_run", 16'(bus.in_ready), 16'd0);
      cyc = 0;
      while (!bus.out_valid && cyc < 20) begin
         tick();
         cyc++;
      end
      check("latency", 16'(cyc), 16'd4);
      e = sb.pop_front();
      check("sum", bus.sum, e.sum);
      check("cout", 16'(bus.cout), 16'(e.cout));
      check("ovf", 16'(bus.ovf), 16'(e.ovf));
      check("busy_done", 16'(bus.busy), 16'd1);
      for (int k = 0; k < hold; k++) begin
         if (k == 1) begin
            bus.in_valid = 1'b1;
            bus.a        = 16'hAAAA;
            bus.b        = 16'hAAAA;
         end
         tick();
         bus.in_valid = 1'b0;
         check("bp_out_valid", 16'(bus.out_valid), 16'd1);
         check("bp_in_ready", 16'(bus.in_ready), 16'd0);
         check("bp_sum", bus.sum, e.sum);
         check("bp_cout", 16'(bus.cout), 16'(e.cout));
         check("bp_ovf", 16'(bus.ovf), 16'(e.ovf));
      end
      bus.out_ready = 1'b1;
      tick();
      check("release_out_valid", 16'(bus.out_valid), 16'd0);
      check("release_in_ready", 16'(bus.in_ready), 16'd1);
      check("release_busy", 16'(bus.busy), 16'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      res_t e;
      logic [15:0] ra, rb;
      logic        rs;
      logic        seen;

      vecs.push_back('{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0});
      vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0});
      vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1});
      vecs.push_back('{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1});
`ifdef SUBTRACT_EN
      vecs.push_back('{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0});
      vecs.push_back('{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1});
`endif

      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
`ifdef SUBTRACT_EN
      bus.sub       = 1'b0;
`endif
      repeat (2) tick();
      check("rst_in_ready", 16'(bus.in_ready), 16'd1);
      check("rst_out_valid", 16'(bus.out_valid), 16'd0);
      check("rst_busy", 16'(bus.busy), 16'd0);
      check("rst_sum", bus.sum, 16'h0000);
      check("rst_cout", 16'(bus.cout), 16'd0);
      check("rst_ovf", 16'(bus.ovf), 16'd0);
      reset = 1'b0;
      tick();

      foreach (vecs[i]) begin
         v      = vecs[i];
         e.sum  = v.sum;
         e.cout = v.cout;
         e.ovf  = v.ovf;
         run_op(v.a, v.b, v.sub, e, 0);
      end

      // Backpressure with an ignored in_valid pulse during DONE.
      run_op(16'h0F0F, 16'h0101, 1'b0, model(16'h0F0F, 16'h0101, 1'b0), 3);
      tick();
      check("bp_no_accept", 16'(bus.busy), 16'd0);

      for (int i = 0; i < 6; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
`ifdef SUBTRACT_EN
         rs = 1'($urandom_range(0, 1));
`else
         rs = 1'b0;
`endif
         run_op(ra, rb, rs, model(ra, rb, rs), i % 2);
      end

      // Reset after two RUN edges aborts the operation.
      bus.a         = 16'h1111;
      bus.b         = 16'h2222;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      repeat (2) tick();
      check("mid_busy", 16'(bus.busy), 16'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_in_ready", 16'(bus.in_ready), 16'd1);
      check("abort_out_valid", 16'(bus.out_valid), 16'd0);
      check("abort_busy", 16'(bus.busy), 16'd0);
      check("abort_sum", bus.sum, 16'h0000);
      seen = 1'b0;
      repeat (6) begin
         tick();
         seen |= bus.out_valid;
      end
      check("abort_no_valid", 16'(seen), 16'd0);
      e.sum  = 16'h0007;
      e.cout = 1'b0;
      e.ovf  = 1'b0;
      run_op(16'h0003, 16'h0004, 1'b0, e, 0);

      check("sb_empty", 16'(sb.size()), 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
